vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA timing and text-cell generator for the 50 MHz pixel clock domain. It produces the sync outputs, pixel coordinates, character-cell coordinates and glyph load/draw strobes that drive the text renderer. Timings, cell geometry and strobe lead are generic. A runtime text mode selects one of two character heights, switched only at a frame boundary. Positions come from incremental counters with no divide or modulo logic.

## Interface
Parameters:
- H_VISIBLE, 800, visible pixels per line
- H_FRONT, 56, horizontal front porch (pixels)
- H_SYNC, 120, hsync pulse width (pixels)
- H_BACK, 64, horizontal back porch (pixels)
- V_VISIBLE, 600, visible lines per frame
- V_FRONT, 37, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BACK, 23, vertical back porch (lines)
- CHAR_W, 8, cell width in pixels
- CHAR_H0, 10, cell height in mode 0
- CHAR_H1, 16, cell height in mode 1
- LOAD_LEAD, 4, cycles between load strobe and cell start (1..CHAR_W-1)
- BLINK_FRAMES, 36, frames per blink half-period

Ports:
- clk  in  1  pixel clock, 50 MHz
- reset  in  1  asynchronous, active-high
- mode_req  in  1  requested text mode (0: CHAR_H0, 1: CHAR_H1)
- mode  out  1  committed text mode
- hsync, vsync  out  1  active-low sync pulses
- xpos, ypos  out  COORDINATE_WIDTH  line and frame counters
- xchar  out  CHARWIDTH bits  pixel index inside the cell
- ychar  out  CHARHEIGHT bits  line index inside the cell
- xtext  out  TEXTCOLS bits  column of the cell being loaded or drawn
- ytext  out  TEXTROWS bits  text row
- clk_load_char, clk_draw_char  out  1  one-cycle glyph strobes
- drawing  out  1  pixel is in the visible area
- line_start, frame_start  out  1  one-cycle pulses at xpos==0 and at (xpos,ypos)==(0,0)
- blink  out  1  blink phase

## Operation
- Each line runs back porch, visible, front porch, then sync. Each frame follows the same order in lines.
- xpos counts 0..H_TOTAL-1 and wraps to 0. ypos increments when xpos wraps, and itself wraps at V_TOTAL-1.
- hsync is low for xpos in [H_BACK+H_VISIBLE+H_FRONT, H_TOTAL). vsync is low over the equivalent range of ypos.
- drawing is high for xpos in [H_BACK, H_BACK+H_VISIBLE) and ypos in [V_BACK, V_BACK+V_VISIBLE).
- Cell counters:
  - xchar resets to 0 at xpos==H_BACK and counts modulo CHAR_W. It is 0 outside the visible region.
  - ychar and ytext reset at ypos==V_BACK. ychar counts modulo the active cell height. ytext increments when ychar wraps.
- Load and draw strobes:
  - clk_load_char fires at xpos==H_BACK-LOAD_LEAD+k·CHAR_W, for k in 0..H_VISIBLE/CHAR_W-1.
  - At each load strobe, xtext takes the value k. xtext holds between strobes.
  - clk_draw_char fires at xpos==H_BACK+k·CHAR_W.
- Strobes and drawing are suppressed outside the vertical visible range.
- Partial last row: in mode 1, 600/16 leaves rows 0..36 full, and row 37 covers ychar 0..7. Row 37 is emitted normally; the renderer blanks rows ≥ ROWS(mode).
- Mode change:
  - mode_req is sampled on the cycle where xpos==H_TOTAL-1 and ypos==V_TOTAL-1.
  - mode updates at the following frame_start. It never changes mid-frame.
- Reset (asynchronous, including mid-frame) clears:
  - all counters, xtext, ytext, mode, blink and the blink counter;
  - drawing, the strobes, line_start and frame_start, which go to 0;
  - hsync and vsync, which are forced to 1.
  
  After release, the first rising edge is xpos=0, ypos=0, and frame_start=1 on that cycle.

## Timing
- Every output is a register, computed from next-state values so that it is coherent with xpos/ypos in the same cycle. There is no cycle skew between any two outputs.
- With default parameters:
  - H_TOTAL=1040, V_TOTAL=666.
  - hsync low for xpos 920..1039; vsync low for ypos 660..665.
  - drawing for xpos 64..863 and ypos 23..622.
- Latency from mode_req to mode is at most one frame plus one cycle.

## Configuration
- With VGA_TIMING_BLINK_EN defined:
  - a frame counter counts frame_start pulses modulo BLINK_FRAMES;
  - blink toggles on each wrap (default 0.5 s half-period at 72 Hz).
- Without VGA_TIMING_BLINK_EN: blink is tied to 0 and no frame counter is synthesised.

## Structure
- The shared package/header holds:
  - COORDINATE_WIDTH, CHARWIDTH, CHARHEIGHT, TEXTCOLS and TEXTROWS widths and ranges;
  - derived totals and sync/visible bounds;
  - the mode encoding constants.
- One sub-module, vga_cell_counter, provides a generic "start at position, count modulo N, carry index" counter. It is instantiated for x (xchar) and for y (ychar/ytext), with the y instance's modulus selected by mode.

## Test plan
- Reset, then release → xpos=0, ypos=0, frame_start=1; next cycle xpos=1; hsync=vsync=1 throughout reset.
- Run one line → hsync falls at xpos=920 and rises at the wrap to 0; line_start period is 1040 cycles; clk_load_char pulses at 60,68,…,852 (100 pulses) with xtext=0..99; clk_draw_char pulses at 64..856.
- Run one frame in mode 0 → vsync low for ypos 660..665; ytext reaches 59 with ychar=9 at ypos=622; drawing count is 480000.
- Set mode_req=1 mid-frame → mode stays 0 until the next frame_start, then becomes 1; ytext reaches 37 with ychar 0..7 at ypos 615..622.
- Assert reset at xpos=500, ypos=300 → all outputs take their reset values asynchronously; the sequence restarts cleanly at (0,0) after release.
- With VGA_TIMING_BLINK_EN and BLINK_FRAMES=2 → blink toggles every 2 frame_start pulses. Without the macro, blink stays constant 0.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared widths, default timing, text-mode encoding and small helpers for the
// VGA timing / text-cell generator.
package vga_timing_gen_pkg;

  localparam int COORDINATE_WIDTH = 11;
  localparam int CHARWIDTH        = 3;
  localparam int CHARHEIGHT       = 4;
  localparam int TEXTCOLS         = 7;
  localparam int TEXTROWS         = 6;

  typedef logic [COORDINATE_WIDTH-1:0] coord_t;

  typedef enum logic {
    MODE_H0 = 1'b0,
    MODE_H1 = 1'b1
  } text_mode_e;

  // 800x600 @ 72 Hz from a 50 MHz pixel clock
  localparam int H_VISIBLE_DEF    = 800;
  localparam int H_FRONT_DEF      = 56;
  localparam int H_SYNC_DEF       = 120;
  localparam int H_BACK_DEF       = 64;
  localparam int V_VISIBLE_DEF    = 600;
  localparam int V_FRONT_DEF      = 37;
  localparam int V_SYNC_DEF       = 6;
  localparam int V_BACK_DEF       = 23;
  localparam int CHAR_W_DEF       = 8;
  localparam int CHAR_H0_DEF      = 10;
  localparam int CHAR_H1_DEF      = 16;
  localparam int LOAD_LEAD_DEF    = 4;
  localparam int BLINK_FRAMES_DEF = 36;

  function automatic int span_total(input int visible, input int front,
                                    input int sync, input int back);
    return back + visible + front + sync;
  endfunction

  function automatic logic in_span(input coord_t pos, input coord_t lo, input coord_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_cell_counter.sv
// Next-state step for a cell counter: restart at a position, count modulo a
// runtime modulus, and carry into a cell index on each wrap.
module vga_cell_counter #(
  parameter int CNT_W = 3,
  parameter int IDX_W = 7
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic [IDX_W-1:0] idx,
  input  logic             clear,
  input  logic             start,
  input  logic             step,
  input  logic [CNT_W:0]   modulus,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic [IDX_W-1:0] idx_nxt
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_nxt = cnt;
    idx_nxt = idx;
    if (clear || start) begin
      cnt_nxt = '0;
      idx_nxt = '0;
    end else if (step) begin
      if ({1'b0, cnt} == modulus - (CNT_W + 1)'(1)) begin
        cnt_nxt = '0;
        idx_nxt = idx + IDX_W'(1);
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync, pixel/cell coordinates and glyph strobes; every output is a register
// fed from next-state values. Optional blink counter: VGA_TIMING_BLINK_EN.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_VISIBLE    = H_VISIBLE_DEF,
  parameter int H_FRONT      = H_FRONT_DEF,
  parameter int H_SYNC       = H_SYNC_DEF,
  parameter int H_BACK       = H_BACK_DEF,
  parameter int V_VISIBLE    = V_VISIBLE_DEF,
  parameter int V_FRONT      = V_FRONT_DEF,
  parameter int V_SYNC       = V_SYNC_DEF,
  parameter int V_BACK       = V_BACK_DEF,
  parameter int CHAR_W       = CHAR_W_DEF,
  parameter int CHAR_H0      = CHAR_H0_DEF,
  parameter int CHAR_H1      = CHAR_H1_DEF,
  parameter int LOAD_LEAD    = LOAD_LEAD_DEF,
  parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mode_req,
  output logic                        mode,
  output logic                        hsync,
  output logic                        vsync,
  output logic [COORDINATE_WIDTH-1:0] xpos,
  output logic [COORDINATE_WIDTH-1:0] ypos,
  output logic [CHARWIDTH-1:0]        xchar,
  output logic [CHARHEIGHT-1:0]       ychar,
  output logic [TEXTCOLS-1:0]         xtext,
  output logic [TEXTROWS-1:0]         ytext,
  output logic                        clk_load_char,
  output logic                        clk_draw_char,
  output logic                        drawing,
  output logic                        line_start,
  output logic                        frame_start,
  output logic                        blink
);

  localparam int H_TOTAL = span_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = span_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t H_VIS_LO   = coord_t'(H_BACK);
  localparam coord_t H_VIS_HI   = coord_t'(H_BACK + H_VISIBLE);
  localparam coord_t H_SYNC_LO  = coord_t'(H_BACK + H_VISIBLE + H_FRONT);
  localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
  localparam coord_t V_VIS_LO   = coord_t'(V_BACK);
  localparam coord_t V_VIS_HI   = coord_t'(V_BACK + V_VISIBLE);
  localparam coord_t V_SYNC_LO  = coord_t'(V_BACK + V_VISIBLE + V_FRONT);
  localparam coord_t LOAD_FIRST = coord_t'(H_BACK - LOAD_LEAD);
  // Loads for k >= 1 land LOAD_LEAD pixels before the end of the previous cell.
  localparam coord_t LOAD_LIMIT = coord_t'(H_BACK + H_VISIBLE - LOAD_LEAD);

  localparam logic [CHARWIDTH-1:0]  LOAD_PHASE = CHARWIDTH'(CHAR_W - LOAD_LEAD);
  localparam logic [CHARWIDTH:0]    CELL_W     = (CHARWIDTH + 1)'(CHAR_W);
  localparam logic [CHARHEIGHT:0]   CELL_H0    = (CHARHEIGHT + 1)'(CHAR_H0);
  localparam logic [CHARHEIGHT:0]   CELL_H1    = (CHARHEIGHT + 1)'(CHAR_H1);

  if (LOAD_LEAD < 1 || LOAD_LEAD >= CHAR_W || BLINK_FRAMES < 1) begin : g_param_check
    $error("vga_timing_gen: LOAD_LEAD must be 1..CHAR_W-1 and BLINK_FRAMES >= 1");
  end

  // Low during reset so the first edge after release lands on (0,0).
  logic                 running;
  coord_t               x_nxt, y_nxt;
  logic                 h_vis_nxt, v_vis_nxt;
  logic                 line_start_nxt, frame_start_nxt;
  logic                 load_first, load_nxt, draw_nxt;
  text_mode_e           mode_nxt;
  logic [CHARWIDTH-1:0] xchar_nxt;
  logic [TEXTCOLS-1:0]  xcol, xcol_nxt, xtext_nxt;
  logic [CHARHEIGHT-1:0] ychar_nxt;
  logic [TEXTROWS-1:0]  ytext_nxt;

  always_comb begin
    x_nxt = '0;
    y_nxt = '0;
    if (running) begin
      x_nxt = (xpos == H_LAST) ? '0 : xpos + coord_t'(1);
      y_nxt = ypos;
      if (xpos == H_LAST) y_nxt = (ypos == V_LAST) ? '0 : ypos + coord_t'(1);
    end
  end

  assign h_vis_nxt       = in_span(x_nxt, H_VIS_LO, H_VIS_HI);
  assign v_vis_nxt       = in_span(y_nxt, V_VIS_LO, V_VIS_HI);
  assign line_start_nxt  = (x_nxt == '0);
  assign frame_start_nxt = line_start_nxt && (y_nxt == '0);

  // mode_req is captured on the last pixel of the frame, so mode only moves with frame_start.
  assign mode_nxt = (running && xpos == H_LAST && ypos == V_LAST) ? text_mode_e'(mode_req)
                                                                   : text_mode_e'(mode);

  vga_cell_counter #(.CNT_W(CHARWIDTH), .IDX_W(TEXTCOLS)) u_x_cell (
    .cnt     (xchar),
    .idx     (xcol),
    .clear   (!h_vis_nxt),
    .start   (x_nxt == H_VIS_LO),
    .step    (1'b1),
    .modulus (CELL_W),
    .cnt_nxt (xchar_nxt),
    .idx_nxt (xcol_nxt)
  );

  vga_cell_counter #(.CNT_W(CHARHEIGHT), .IDX_W(TEXTROWS)) u_y_cell (
    .cnt     (ychar),
    .idx     (ytext),
    .clear   (!v_vis_nxt),
    .start   (y_nxt == V_VIS_LO),
    .step    (line_start_nxt),
    .modulus ((mode_nxt == MODE_H1) ? CELL_H1 : CELL_H0),
    .cnt_nxt (ychar_nxt),
    .idx_nxt (ytext_nxt)
  );

  assign load_first = (x_nxt == LOAD_FIRST);
  assign load_nxt   = v_vis_nxt && (load_first ||
                      (h_vis_nxt && xchar_nxt == LOAD_PHASE && x_nxt < LOAD_LIMIT));
  assign draw_nxt   = v_vis_nxt && h_vis_nxt && (xchar_nxt == '0);

  always_comb begin
    xtext_nxt = xtext;
    if (load_nxt) xtext_nxt = load_first ? '0 : xcol_nxt + TEXTCOLS'(1);
  end

  // NOTE: asynchronous reset drives every flop; sync outputs idle high, the rest clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running       <= 1'b0;
      xpos          <= '0;
      ypos          <= '0;
      xchar         <= '0;
      xcol          <= '0;
      ychar         <= '0;
      xtext         <= '0;
      ytext         <= '0;
      mode          <= 1'b0;
      hsync         <= 1'b1;
      vsync         <= 1'b1;
      drawing       <= 1'b0;
      clk_load_char <= 1'b0;
      clk_draw_char <= 1'b0;
      line_start    <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      running       <= 1'b1;
      xpos          <= x_nxt;
      ypos          <= y_nxt;
      xchar         <= xchar_nxt;
      xcol          <= xcol_nxt;
      ychar         <= ychar_nxt;
      xtext         <= xtext_nxt;
      ytext         <= ytext_nxt;
      mode          <= mode_nxt;
      hsync         <= ~(x_nxt >= H_SYNC_LO);
      vsync         <= ~(y_nxt >= V_SYNC_LO);
      drawing       <= h_vis_nxt && v_vis_nxt;
      clk_load_char <= load_nxt;
      clk_draw_char <= draw_nxt;
      line_start    <= line_start_nxt;
      frame_start   <= frame_start_nxt;
    end
  end

`ifdef VGA_TIMING_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic [BLINK_W-1:0] frame_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      blink     <= 1'b0;
    end else if (frame_start_nxt) begin
      if (frame_cnt == BLINK_LAST) begin
        frame_cnt <= '0;
        blink     <= ~blink;
      end else begin
        frame_cnt <= frame_cnt + BLINK_W'(1);
      end
    end
  end
`else
  assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken 50x28 raster: position table,
// line/frame sweeps, mode switch, mid-frame reset and blink.
module tb_vga_timing_gen;
  import vga_timing_gen_pkg::*;

  // Raster: H = 8 back + 32 visible + 4 front + 6 sync = 50; V = 3 + 20 + 2 + 3 = 28
  localparam int HV = 32, HF = 4, HS = 6, HB = 8;
  localparam int VV = 20, VF = 2, VS = 3, VB = 3;
  localparam int HT = 50, VT = 28;

  logic clk = 1'b0;
  logic reset;
  logic mode_req;
  logic mode, hsync, vsync, clk_load_char, clk_draw_char, drawing;
  logic line_start, frame_start, blink;
  logic [COORDINATE_WIDTH-1:0] xpos, ypos;
  logic [CHARWIDTH-1:0]  xchar;
  logic [CHARHEIGHT-1:0] ychar;
  logic [TEXTCOLS-1:0]   xtext;
  logic [TEXTROWS-1:0]   ytext;

  int checks = 0;
  int errors = 0;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CHAR_W(8), .CHAR_H0(4), .CHAR_H1(6), .LOAD_LEAD(4), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .mode_req(mode_req), .mode(mode),
    .hsync(hsync), .vsync(vsync), .xpos(xpos), .ypos(ypos),
    .xchar(xchar), .ychar(ychar), .xtext(xtext), .ytext(ytext),
    .clk_load_char(clk_load_char), .clk_draw_char(clk_draw_char),
    .drawing(drawing), .line_start(line_start), .frame_start(frame_start),
    .blink(blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x, y;
    int hs, vs, dr, ld, dc, ls, fs;
    int xc, yc, xt, yt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int x, int y, int hs, int vs, int dr, int ld, int dc,
                              int ls, int fs, int xc, int yc, int xt, int yt);
    vec_t v;
    v.x = x; v.y = y; v.hs = hs; v.vs = vs; v.dr = dr; v.ld = ld; v.dc = dc;
    v.ls = ls; v.fs = fs; v.xc = xc; v.yc = yc; v.xt = xt; v.yt = yt;
    return v;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (x=%0d y=%0d)", name, actual, expected, xpos, ypos);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_pos(input int x, input int y);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(int'(xpos) == x && int'(ypos) == y) && n < 3000);
    if (!(int'(xpos) == x && int'(ypos) == y)) begin
      checks++;
      errors++;
      $display("FAIL goto: position (%0d,%0d) not reached in 3000 cycles, at (%0d,%0d)",
               x, y, xpos, ypos);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_load, n_draw, n_dr, n_hs, first_hs, n_vs, first_vs, max_yt, n_ls, n_fs;
    int exp_blink[3];

    // x, y, hs, vs, dr, ld, dc, ls, fs, xchar, ychar, xtext, ytext (mode 0, cell 8x4)
    vecs.push_back(mk( 4,  2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 4,  3, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 8,  3, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(12,  3, 1, 1, 1, 1, 0, 0, 0, 4, 0, 1, 0));
    vecs.push_back(mk(15,  3, 1, 1, 1, 0, 0, 0, 0, 7, 0, 1, 0));
    vecs.push_back(mk(16,  3, 1, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(28,  3, 1, 1, 1, 1, 0, 0, 0, 4, 0, 3, 0));
    vecs.push_back(mk(36,  3, 1, 1, 1, 0, 0, 0, 0, 4, 0, 3, 0));
    vecs.push_back(mk(39,  3, 1, 1, 1, 0, 0, 0, 0, 7, 0, 3, 0));
    vecs.push_back(mk(40,  3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0));
    vecs.push_back(mk(44,  3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0));
    vecs.push_back(mk(49,  3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0));
    vecs.push_back(mk( 0,  4, 1, 1, 0, 0, 0, 1, 0, 0, 1, 3, 0));
    vecs.push_back(mk( 4,  4, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(10,  7, 1, 1, 1, 0, 0, 0, 0, 2, 0, 0, 1));
    vecs.push_back(mk(20, 22, 1, 1, 1, 1, 0, 0, 0, 4, 3, 2, 4));
    vecs.push_back(mk( 8, 23, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0));
    vecs.push_back(mk( 0, 25, 1, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0));
    vecs.push_back(mk(47, 27, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0));
    vecs.push_back(mk( 0,  0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 3, 0));

`ifdef VGA_TIMING_BLINK_EN
    exp_blink = '{1, 1, 0};
`else
    exp_blink = '{0, 0, 0};
`endif

    // Reset and release
    reset = 1'b1;
    mode_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_xpos", xpos, 0);
    check("rst_frame_start", frame_start, 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("rel_xpos", xpos, 0);
    check("rel_ypos", ypos, 0);
    check("rel_frame_start", frame_start, 1);
    check("rel_line_start", line_start, 1);
    step();
    check("rel_xpos_next", xpos, 1);
    check("rel_frame_start_next", frame_start, 0);

    // Position table
    foreach (vecs[i]) begin
      goto_pos(vecs[i].x, vecs[i].y);
      check($sformatf("v%0d_hsync", i), hsync, vecs[i].hs);
      check($sformatf("v%0d_vsync", i), vsync, vecs[i].vs);
      check($sformatf("v%0d_drawing", i), drawing, vecs[i].dr);
      check($sformatf("v%0d_load", i), clk_load_char, vecs[i].ld);
      check($sformatf("v%0d_draw", i), clk_draw_char, vecs[i].dc);
      check($sformatf("v%0d_line_start", i), line_start, vecs[i].ls);
      check($sformatf("v%0d_frame_start", i), frame_start, vecs[i].fs);
      check($sformatf("v%0d_xchar", i), xchar, vecs[i].xc);
      check($sformatf("v%0d_ychar", i), ychar, vecs[i].yc);
      check($sformatf("v%0d_xtext", i), xtext, vecs[i].xt);
      check($sformatf("v%0d_ytext", i), ytext, vecs[i].yt);
    end

    // One visible line: loads at 4,12,20,28 with xtext 0..3, draws x4, hsync low 44..49
    goto_pos(0, 3);
    n_load = 0; n_draw = 0; n_dr = 0; n_hs = 0; first_hs = -1;
    for (int c = 0; c < HT; c++) begin
      if (clk_load_char) begin
        check("line_load_x", int'(xpos), 4 + 8 * n_load);
        check("line_load_xtext", int'(xtext), n_load);
        n_load++;
      end
      if (clk_draw_char) n_draw++;
      if (drawing) n_dr++;
      if (!hsync) begin
        if (first_hs < 0) first_hs = int'(xpos);
        n_hs++;
      end
      step();
    end
    check("line_loads", n_load, 4);
    check("line_draws", n_draw, 4);
    check("line_drawing", n_dr, 32);
    check("line_hsync_low", n_hs, 6);
    check("line_hsync_fall", first_hs, 44);
    check("line_period_x", xpos, 0);
    check("line_period_ls", line_start, 1);
    check("line_wrap_hsync", hsync, 1);

    // One frame in mode 0
    goto_pos(0, 0);
    n_dr = 0; n_vs = 0; first_vs = -1; max_yt = 0; n_ls = 0; n_fs = 0;
    for (int c = 0; c < HT * VT; c++) begin
      if (drawing) n_dr++;
      if (line_start) n_ls++;
      if (frame_start) n_fs++;
      if (!vsync) begin
        if (first_vs < 0) first_vs = int'(ypos);
        n_vs++;
      end
      if (int'(ytext) > max_yt) max_yt = int'(ytext);
      if (xpos == 0 && ypos == 22) begin
        check("frame_last_ytext", ytext, 4);
        check("frame_last_ychar", ychar, 3);
      end
      step();
    end
    check("frame_drawing", n_dr, HV * VV);
    check("frame_vsync_low", n_vs, VS * HT);
    check("frame_vsync_fall", first_vs, 25);
    check("frame_max_ytext", max_yt, 4);
    check("frame_line_starts", n_ls, VT);
    check("frame_frame_starts", n_fs, 1);
    check("frame_wrap_fs", frame_start, 1);

    // Mode switch requested mid-frame: commits only at the next frame_start
    goto_pos(10, 10);
    mode_req = 1'b1;
    check("mode_mid_frame", mode, 0);
    goto_pos(HT - 1, VT - 1);
    check("mode_last_pixel", mode, 0);
    step();
    check("mode_frame_start", frame_start, 1);
    check("mode_committed", mode, 1);
    goto_pos(0, 20);
    check("m1_y20_ytext", ytext, 2);
    check("m1_y20_ychar", ychar, 5);
    goto_pos(0, 21);
    check("m1_y21_ytext", ytext, 3);
    check("m1_y21_ychar", ychar, 0);
    goto_pos(8, 22);
    check("m1_y22_ytext", ytext, 3);
    check("m1_y22_ychar", ychar, 1);
    check("m1_y22_draw", clk_draw_char, 1);

    // Asynchronous reset in the middle of the visible area
    goto_pos(20, 10);
    check("pre_rst_drawing", drawing, 1);
    check("pre_rst_mode", mode, 1);
    #2;
    reset = 1'b1;
    mode_req = 1'b0;
    #1;
    check("arst_xpos", xpos, 0);
    check("arst_ypos", ypos, 0);
    check("arst_hsync", hsync, 1);
    check("arst_vsync", vsync, 1);
    check("arst_drawing", drawing, 0);
    check("arst_load", clk_load_char, 0);
    check("arst_xchar", xchar, 0);
    check("arst_xtext", xtext, 0);
    check("arst_ytext", ytext, 0);
    check("arst_ychar", ychar, 0);
    check("arst_mode", mode, 0);
    check("arst_blink", blink, 0);
    repeat (2) step();
    check("arst_hold_xpos", xpos, 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("arst_rel_xpos", xpos, 0);
    check("arst_rel_ypos", ypos, 0);
    check("arst_rel_fs", frame_start, 1);
    check("arst_rel_blink", blink, 0);
    step();
    check("arst_rel_xpos_next", xpos, 1);

    // Blink across the next three frame_start pulses
    for (int f = 0; f < 3; f++) begin
      goto_pos(0, 0);
      check($sformatf("blink_f%0d_fs", f + 2), frame_start, 1);
      check($sformatf("blink_f%0d", f + 2), blink, exp_blink[f]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
